// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_pkg
// Purpose  : Shared types and constants for the CPU memory responder:
//            controller state encoding, data word width and the default
//            poison word returned on an aborted load.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int unsigned c_WORD_W = 32;
    localparam logic [31:0] c_POISON = 32'hDEAD_BEEF;

    // Controller states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_watchdog
// Purpose  : Counts stalled cycles of an outstanding backing-memory access and
//            flags the cycle in which the TIMEOUT-th stalled cycle is reached.
// Ports    : clk       in  clock
//            rst       in  synchronous active-high reset
//            i_clear   in  restart the count (held while the controller idles)
//            i_enable  in  current cycle is a stalled cycle (req & ~ack)
//            o_expire  out this stalled cycle is the TIMEOUT-th one
// Revision : 1.0 - initial release
// ============================================================================
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned c_CNT_W = $clog2(TIMEOUT);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // r_count holds the stalled cycles already elapsed, so the TIMEOUT-th
    // stalled cycle is the one that sees TIMEOUT-1. The abort then lands on
    // the following edge, giving exactly TIMEOUT cycles of bmem_req.
    assign o_expire = i_enable && (r_count == c_CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_responder
// Purpose  : Memory-controller end of the CPU memory interface. Serves the
//            instruction port and the data port from one single-ported,
//            variable-latency backing memory. Data accesses win over fetches,
//            a one-entry instruction buffer hides fetch latency on hits, and a
//            watchdog aborts accesses the backing memory never acknowledges.
// Ports    : clk            in   clock
//            rst            in   synchronous active-high reset
//            mem_instr_addr in   32  CPU fetch byte address
//            mem_instr_data out  32  buffered instruction (registered)
//            instr_vld      out  1   buffer holds mem_instr_addr's word
//            mem_addr       in   32  CPU data byte address
//            mem_wr_data    in   32  CPU store data
//            mem_wr, mem_rd in   1   store / load, held until mem_valid
//            mem_rd_data    out  32  load data (registered)
//            mem_valid      out  1   one-cycle completion pulse
//            bmem_req       out  1   backing request, held until ack/abort
//            bmem_we        out  1   backing write enable
//            bmem_addr      out  WADDR_W backing word address
//            bmem_wdata     out  32  backing write data
//            bmem_ack       in   1   backing completion, rdata valid with it
//            bmem_rdata     in   32  backing read data
//            timeout_err    out  1   sticky abort flag, cleared by rst only
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned          WADDR_W = 14,
    parameter int unsigned          TIMEOUT = 64,
    parameter logic [c_WORD_W-1:0]  POISON  = c_POISON
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_instr_addr,
    output logic [31:0]         mem_instr_data,
    output logic                instr_vld,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wr_data,
    input  logic                mem_wr,
    input  logic                mem_rd,
    output logic [31:0]         mem_rd_data,
    output logic                mem_valid,
    output logic                bmem_req,
    output logic                bmem_we,
    output logic [WADDR_W-1:0]  bmem_addr,
    output logic [31:0]         bmem_wdata,
    input  logic                bmem_ack,
    input  logic [31:0]         bmem_rdata,
    output logic                timeout_err
);

    state_t r_state;
    state_t w_state_nxt;

    logic                r_bmem_req;
    logic                r_bmem_we;
    logic [WADDR_W-1:0]  r_bmem_addr;
    logic [31:0]         r_bmem_wdata;
    logic                r_mem_valid;
    logic [31:0]         r_mem_rd_data;
    logic [31:0]         r_ibuf_data;
    logic [29:0]         r_ibuf_tag;
    logic                r_tag_valid;
    logic [29:0]         r_fetch_tag;
    logic                r_timeout_err;

    logic                w_data_pend;
    logic                w_bmem_done;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_wd_expire;
    logic                w_unused_addr;

    // A request still held high during its own mem_valid cycle has already
    // been served and must not start a second access.
    assign w_data_pend = (mem_wr || mem_rd) && !r_mem_valid;

    // Acks are only honoured while a request is outstanding; a late ack
    // after an abort is dropped.
    assign w_bmem_done = r_bmem_req && bmem_ack;

    assign instr_vld   = r_tag_valid && (r_ibuf_tag == mem_instr_addr[31:2]);

    assign w_wd_clear  = (r_state == IDLE);
    assign w_wd_enable = (r_state != IDLE) && r_bmem_req && !bmem_ack;

    // Byte-offset and above-window address bits do not select a word.
    assign w_unused_addr = ^{mem_addr[31:WADDR_W+2], mem_addr[1:0], mem_instr_addr[1:0]};

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: data before fetch, completion or abort returns home
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_data_pend) begin
                    w_state_nxt = DATA;
                end else if (!instr_vld) begin
                    w_state_nxt = FETCH;
                end
            end
            DATA, FETCH: begin
                if (w_bmem_done || w_wd_expire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Backing-memory port, CPU response and instruction buffer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bmem_req    <= 1'b0;
            r_bmem_we     <= 1'b0;
            r_bmem_addr   <= '0;
            r_bmem_wdata  <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_rd_data <= '0;
            r_ibuf_data   <= '0;
            r_ibuf_tag    <= '0;
            r_tag_valid   <= 1'b0;
            r_fetch_tag   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mem_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_data_pend) begin
                        // Simultaneous wr and rd is treated as a store.
                        r_bmem_req   <= 1'b1;
                        r_bmem_we    <= mem_wr;
                        r_bmem_addr  <= mem_addr[WADDR_W+1:2];
                        r_bmem_wdata <= mem_wr_data;
                    end else if (!instr_vld) begin
                        // The buffer is invalid until this fetch lands, so an
                        // abort naturally leaves it invalid and forces a retry.
                        r_bmem_req  <= 1'b1;
                        r_bmem_we   <= 1'b0;
                        r_bmem_addr <= mem_instr_addr[WADDR_W+1:2];
                        r_fetch_tag <= mem_instr_addr[31:2];
                        r_tag_valid <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_bmem_done) begin
                        r_bmem_req  <= 1'b0;
                        r_mem_valid <= 1'b1;
                        if (!r_bmem_we) begin
                            r_mem_rd_data <= bmem_rdata;
                        end
                    end else if (w_wd_expire) begin
                        // The CPU is still released so it cannot hang.
                        r_bmem_req    <= 1'b0;
                        r_mem_valid   <= 1'b1;
                        r_timeout_err <= 1'b1;
                        if (!r_bmem_we) begin
                            r_mem_rd_data <= POISON;
                        end
                    end
                end
                FETCH: begin
                    if (w_bmem_done) begin
                        // Tag is the address latched at fetch start, even if
                        // the CPU has since moved on.
                        r_bmem_req  <= 1'b0;
                        r_ibuf_data <= bmem_rdata;
                        r_ibuf_tag  <= r_fetch_tag;
                        r_tag_valid <= 1'b1;
                    end else if (w_wd_expire) begin
                        r_bmem_req    <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end
                end
                default: r_bmem_req <= 1'b0;
            endcase
        end
    end

    assign bmem_req       = r_bmem_req;
    assign bmem_we        = r_bmem_we;
    assign bmem_addr      = r_bmem_addr;
    assign bmem_wdata     = r_bmem_wdata;
    assign mem_valid      = r_mem_valid;
    assign mem_rd_data    = r_mem_rd_data;
    assign mem_instr_data = r_ibuf_data;
    assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_responder
// Purpose  : Self-checking bench for cpu_mem_responder. A backing-memory
//            responder with configurable latency answers bmem requests; the
//            CPU-visible memory contents are tracked in a separate reference
//            array and every load / fetch result is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    localparam int          WADDR_W = 14;
    localparam int          TIMEOUT = 8;
    localparam logic [31:0] POISON  = 32'hDEAD_BEEF;

    logic               clk;
    logic               rst;
    logic [31:0]        mem_instr_addr;
    logic [31:0]        mem_instr_data;
    logic               instr_vld;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wr_data;
    logic               mem_wr;
    logic               mem_rd;
    logic [31:0]        mem_rd_data;
    logic               mem_valid;
    logic               bmem_req;
    logic               bmem_we;
    logic [WADDR_W-1:0] bmem_addr;
    logic [31:0]        bmem_wdata;
    logic               bmem_ack;
    logic [31:0]        bmem_rdata;
    logic               timeout_err;

    cpu_mem_responder #(
        .WADDR_W (WADDR_W),
        .TIMEOUT (TIMEOUT),
        .POISON  (POISON)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_instr_addr (mem_instr_addr),
        .mem_instr_data (mem_instr_data),
        .instr_vld      (instr_vld),
        .mem_addr       (mem_addr),
        .mem_wr_data    (mem_wr_data),
        .mem_wr         (mem_wr),
        .mem_rd         (mem_rd),
        .mem_rd_data    (mem_rd_data),
        .mem_valid      (mem_valid),
        .bmem_req       (bmem_req),
        .bmem_we        (bmem_we),
        .bmem_addr      (bmem_addr),
        .bmem_wdata     (bmem_wdata),
        .bmem_ack       (bmem_ack),
        .bmem_rdata     (bmem_rdata),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory models: CPU-visible reference and backing-memory storage
    // ------------------------------------------------------------------
    logic [31:0] ref_mem  [256];
    logic [31:0] bmem_arr [256];

    int  lat_cfg = 1;
    bit  hang    = 1'b0;
    int  n_req   = 0;
    int  last_req_cycles = 0;
    int  q_addr  [$];
    bit  q_we    [$];
    logic [31:0] q_wdata [$];

    // Backing responder: acts 1 time unit after each rising edge.
    initial begin
        bit                 busy;
        bit                 stable_ok;
        int                 cnt;
        int                 req_cycles;
        logic [WADDR_W-1:0] cap_addr;
        logic               cap_we;
        logic [31:0]        cap_wdata;
        busy       = 1'b0;
        stable_ok  = 1'b1;
        cnt        = 0;
        req_cycles = 0;
        cap_addr   = '0;
        cap_we     = 1'b0;
        cap_wdata  = '0;
        bmem_ack   = 1'b0;
        bmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bmem_ack = 1'b0;
            if (!bmem_req) begin
                if (busy) begin
                    last_req_cycles = req_cycles;
                    check_eq("bmem_stable", 32'(stable_ok), 32'd1);
                end
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy       = 1'b1;
                    cnt        = lat_cfg;
                    req_cycles = 0;
                    stable_ok  = 1'b1;
                    cap_addr   = bmem_addr;
                    cap_we     = bmem_we;
                    cap_wdata  = bmem_wdata;
                    n_req++;
                    q_addr.push_back(int'(bmem_addr));
                    q_we.push_back(bmem_we);
                    q_wdata.push_back(bmem_wdata);
                end else if (bmem_addr !== cap_addr || bmem_we !== cap_we ||
                             bmem_wdata !== cap_wdata) begin
                    stable_ok = 1'b0;
                end
                req_cycles++;
                if (!hang) begin
                    if (cnt == 0) begin
                        bmem_ack = 1'b1;
                        if (bmem_we) begin
                            bmem_arr[bmem_addr[7:0]] = bmem_wdata;
                            bmem_rdata = $urandom;
                        end else begin
                            bmem_rdata = bmem_arr[bmem_addr[7:0]];
                        end
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU-side helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // exp_lat < 0 disables the latency check.
    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int exp_lat, input bit exp_abort);
        logic [31:0] prev_rd;
        int          word;
        int          lat;
        bit          seen;
        word    = int'(addr[9:2]);
        prev_rd = mem_rd_data;
        mem_addr    = addr;
        mem_wr_data = wdata;
        mem_wr      = wr;
        mem_rd      = ~wr;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 100; c++) begin
            cycle();
            if (mem_valid) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        check_eq("acc_done", 32'(seen), 32'd1);
        if (seen) begin
            if (exp_lat >= 0) check_eq("acc_latency", lat, exp_lat);
            if (wr) check_eq("wr_rd_data_kept", mem_rd_data, prev_rd);
            else    check_eq("rd_data", mem_rd_data, exp_abort ? POISON : ref_mem[word]);
            cycle();
            check_eq("valid_pulse", 32'(mem_valid), 32'd0);
            if (wr && !exp_abort) ref_mem[word] = wdata;
        end
    endtask

    task automatic check_fetch(input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        mem_instr_addr = addr;
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (instr_vld) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("ifetch_vld", 32'(ok), 32'd1);
        check_eq("ifetch_data", mem_instr_data, ref_mem[addr[9:2]]);
    endtask

    task automatic wait_req(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cycle();
            if (bmem_req) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int          nb;
        int          qb;
        bit          ok;
        bit          vbad;
        logic [31:0] a;
        logic [31:0] d;
        int          w;
        bit          wr;

        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            ref_mem[i]  = d;
            bmem_arr[i] = d;
        end
        ref_mem[16]  = 32'h1234_5678;
        bmem_arr[16] = 32'h1234_5678;

        rst            = 1'b1;
        mem_instr_addr = 32'h0;
        mem_addr       = 32'h0;
        mem_wr_data    = 32'h0;
        mem_wr         = 1'b0;
        mem_rd         = 1'b0;
        repeat (3) cycle();

        // Reset state
        check_eq("rst_bmem_req",   32'(bmem_req), 32'd0);
        check_eq("rst_mem_valid",  32'(mem_valid), 32'd0);
        check_eq("rst_instr_vld",  32'(instr_vld), 32'd0);
        check_eq("rst_timeout",    32'(timeout_err), 32'd0);
        check_eq("rst_rd_data",    mem_rd_data, 32'd0);
        check_eq("rst_instr_data", mem_instr_data, 32'd0);
        rst = 1'b0;

        check_fetch(32'h0);

        // Load at 0x40, ack one cycle after req
        lat_cfg = 1;
        nb = n_req;
        qb = q_addr.size();
        do_access(1'b0, 32'h40, 32'h0, 3, 1'b0);
        check_eq("ld_nreq", n_req - nb, 1);
        check_eq("ld_bmem_addr", q_addr[qb], 32'h10);

        // Store 0xCAFEF00D at 0x100, ack after three cycles, then read back
        lat_cfg = 3;
        nb = n_req;
        qb = q_addr.size();
        do_access(1'b1, 32'h100, 32'hCAFE_F00D, 5, 1'b0);
        check_eq("st_nreq", n_req - nb, 1);
        check_eq("st_we", 32'(q_we[qb]), 32'd1);
        check_eq("st_wdata", q_wdata[qb], 32'hCAFE_F00D);
        check_eq("st_backing", bmem_arr[64], 32'hCAFE_F00D);
        lat_cfg = 0;
        do_access(1'b0, 32'h100, 32'h0, 2, 1'b0);

        // Load and ibuf miss in the same cycle: data first, then fetch
        lat_cfg = 2;
        qb = q_addr.size();
        mem_instr_addr = 32'h300;
        do_access(1'b0, 32'h44, 32'h0, -1, 1'b0);
        check_fetch(32'h300);
        check_eq("arb_nreq", q_addr.size() - qb, 2);
        check_eq("arb_first", q_addr[qb], 32'h11);
        check_eq("arb_first_we", 32'(q_we[qb]), 32'd0);
        check_eq("arb_second", q_addr[qb + 1], 32'hC0);
        nb = n_req;
        repeat (5) cycle();
        check_eq("ibuf_hit_noreq", n_req - nb, 0);
        check_eq("ibuf_hit_vld", 32'(instr_vld), 32'd1);

        // Instruction address moves mid-fetch
        lat_cfg = 4;
        qb = q_addr.size();
        mem_instr_addr = 32'h200;
        wait_req("midfetch_req");
        mem_instr_addr = 32'h204;
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bmem_ack) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check_eq("midfetch_ack", 32'(ok), 32'd1);
        cycle();
        check_eq("midfetch_vld_low", 32'(instr_vld), 32'd0);
        check_fetch(32'h204);
        check_eq("midfetch_first", q_addr[qb], 32'h80);
        check_eq("midfetch_second", q_addr[qb + 1], 32'h81);

        // Load never acknowledged: watchdog abort
        hang = 1'b1;
        do_access(1'b0, 32'h48, 32'h0, TIMEOUT + 1, 1'b1);
        check_eq("to_req_cycles", last_req_cycles, TIMEOUT);
        check_eq("to_err", 32'(timeout_err), 32'd1);

        // Fetch never acknowledged: buffer stays invalid, retried later
        mem_instr_addr = 32'h3F0;
        repeat (TIMEOUT + 4) cycle();
        check_eq("to_fetch_vld", 32'(instr_vld), 32'd0);
        hang    = 1'b0;
        lat_cfg = 1;
        check_fetch(32'h3F0);

        // Randomized mix of loads, stores and fetches
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                a = {16'($urandom), 6'd0, 8'($urandom_range(192, 255)), 2'($urandom)};
                check_fetch(a);
            end
            lat_cfg = $urandom_range(0, 4);
            wr = 1'($urandom);
            w  = $urandom_range(0, 191);
            a  = {16'($urandom), 6'd0, 8'(w), 2'($urandom)};
            d  = $urandom;
            do_access(wr, a, d, instr_vld ? lat_cfg + 2 : -1, 1'b0);
        end
        check_eq("to_err_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of an outstanding load
        lat_cfg     = 30;
        mem_addr    = 32'h50;
        mem_rd      = 1'b1;
        wait_req("rstmid_req");
        rst = 1'b1;
        cycle();
        mem_rd = 1'b0;
        check_eq("rstmid_req_low",   32'(bmem_req), 32'd0);
        check_eq("rstmid_we",        32'(bmem_we), 32'd0);
        check_eq("rstmid_addr",      32'(bmem_addr), 32'd0);
        check_eq("rstmid_wdata",     bmem_wdata, 32'd0);
        check_eq("rstmid_valid",     32'(mem_valid), 32'd0);
        check_eq("rstmid_rd_data",   mem_rd_data, 32'd0);
        check_eq("rstmid_instr_dat", mem_instr_data, 32'd0);
        check_eq("rstmid_instr_vld", 32'(instr_vld), 32'd0);
        check_eq("rstmid_timeout",   32'(timeout_err), 32'd0);
        vbad = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (3) begin
            cycle();
            if (mem_valid) vbad = 1'b1;
        end
        check_eq("rstmid_no_valid", 32'(vbad), 32'd0);

        lat_cfg = 1;
        check_fetch(mem_instr_addr);
        do_access(1'b0, 32'h100, 32'h0, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
